// File: rtl/uart_rx.sv
// 8N1 UART receiver on a 16x oversample tick; flags data ready, frame error, overrun.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting on every bit.
module uart_rx (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       clken,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic [7:0] data,
    output logic       rdy,
    output logic       ferr,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] D_TICK = 4'd9;
`else
    localparam logic [3:0] D_TICK = 4'd8;
`endif

    state_t     state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [3:0] smp_q, smp_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic       rdy_q, rdy_d;
    logic       ferr_q, ferr_d;
    logic       overrun_q, overrun_d;
    logic       bit_b;
    logic       at_d;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q, maj_d;

    always_comb begin
        maj_d = maj_q;
        if (clken && state_q != IDLE) begin
            if (smp_q == 4'd7) maj_d[0] = rx_s_q;
            if (smp_q == 4'd8) maj_d[1] = rx_s_q;
        end
        bit_b = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s_q) | (maj_q[1] & rx_s_q);
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) maj_q <= 2'b11;
        else        maj_q <= maj_d;
    end
`else
    always_comb bit_b = rx_s_q;
`endif

    assign at_d = (smp_q == D_TICK);

    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        rdy_d     = rdy_q;
        ferr_d    = ferr_q;
        overrun_d = overrun_q;
        if (rdy_clr) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end
        if (clken) begin
            unique case (state_q)
                IDLE: begin
                    // The detecting tick is sample 0 of the start bit.
                    if (!rx_s_q) begin
                        state_d = START;
                        smp_d   = 4'd1;
                    end
                end
                START: begin
                    smp_d = smp_q + 4'd1;
                    if (at_d && bit_b) begin
                        state_d = IDLE;
                    end else if (smp_q == 4'd15) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    smp_d = smp_q + 4'd1;
                    if (at_d) shreg_d = {bit_b, shreg_q[7:1]};
                    if (smp_q == 4'd15) begin
                        if (bitcnt_q == 3'd7) state_d = STOP;
                        else                  bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                STOP: begin
                    smp_d = smp_q + 4'd1;
                    // Leave at mid-stop so a back-to-back start edge is caught.
                    if (at_d) begin
                        data_d  = shreg_q;
                        ferr_d  = ~bit_b;
                        rdy_d   = 1'b1;
                        if (rdy_q && !rdy_clr) overrun_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            smp_q     <= 4'd0;
            bitcnt_q  <= 3'd0;
            shreg_q   <= 8'h00;
            data_q    <= 8'h00;
            rdy_q     <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            smp_q     <= smp_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign rdy     = rdy_q;
    assign ferr    = ferr_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: random and directed 8N1 frames at 432 clocks per bit.
module tb_uart_rx;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       clken;
    logic       rx      = 1'b1;
    logic       rdy_clr = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic       ferr;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int tcnt   = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_rdy  = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    uart_rx dut (
        .clk_50m(clk_50m),
        .rst_n  (rst_n),
        .clken  (clken),
        .rx     (rx),
        .rdy_clr(rdy_clr),
        .data   (data),
        .rdy    (rdy),
        .ferr   (ferr),
        .overrun(overrun)
    );

    always #10 clk_50m = ~clk_50m;

    always @(posedge clk_50m) tcnt <= (tcnt == 26) ? 0 : tcnt + 1;
    assign clken = (tcnt == 26);

    // Line level seen at a given offset inside a bit period.
    function automatic logic line_at(logic lvl, bit g, int off);
        return (g && off >= 216 && off < 243) ? 1'b1 : lvl;
    endfunction

    // Receiver's view of one bit: samples 7,8,9 land at offsets 24+27*s.
    function automatic logic decide(logic lvl, bit g);
        int ones;
        ones = int'(line_at(lvl, g, 213)) + int'(line_at(lvl, g, 240))
             + int'(line_at(lvl, g, 267));
`ifdef UART_RX_MAJORITY_EN
        return ones >= 2;
`else
        return line_at(lvl, g, 240);
`endif
    endfunction

    function automatic logic [7:0] model_byte(logic [7:0] b, int gfb);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = decide(b[k], gfb == k + 1);
        return r;
    endfunction

    task automatic model_deliver(logic [7:0] b, logic stop, int gfb, bit clr);
        m_ovr  = clr ? 1'b0 : (m_ovr | m_rdy);
        m_rdy  = 1'b1;
        m_data = model_byte(b, gfb);
        m_ferr = ~decide(stop, gfb == 9);
    endtask

    task automatic model_clear();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic align();
        do @(negedge clk_50m); while (!clken);
        @(negedge clk_50m);
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
        model_clear();
    endtask

    task automatic idle_bits(int n);
        rx = 1'b1;
        repeat (n * 432) @(negedge clk_50m);
    endtask

    task automatic send_frame(logic [7:0] b, logic stop, int gfb, bit cont,
                              bit clr, int abort_fb);
        logic lvl;
        if (!cont) align();
        for (int i = 0; i < 10; i++) begin
            lvl = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            for (int c = 0; c < 432; c++) begin
                if (abort_fb == i && c == 100) begin
                    rst_n = 1'b0;
                    rx    = 1'b1;
                    repeat (3) @(negedge clk_50m);
                    return;
                end
                rx      = line_at(lvl, gfb == i, c);
                rdy_clr = clr && i == 9 && clken && c > 200 && c < 260;
                @(negedge clk_50m);
            end
        end
        rdy_clr = 1'b0;
        rx      = 1'b1;
        if (abort_fb < 0) model_deliver(b, stop, gfb, clr);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk_50m);
        checks++;
        if ({data, rdy, ferr, overrun} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000", {data, rdy, ferr, overrun});
        end
        rst_n = 1'b1;
        repeat (30) @(negedge clk_50m);
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_rdy got %b want 0", rdy);
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, -1, 1'b0, 1'b0, -1);
        checks++;
        if (data !== m_data) begin
            errors++;
            $display("FAIL basic_data got %h want %h", data, m_data);
        end
        checks++;
        if ({rdy, ferr, overrun} !== {m_rdy, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL basic_flags got %b want %b", {rdy, ferr, overrun},
                     {m_rdy, m_ferr, m_ovr});
        end
        pulse_clr();
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL basic_clr got %b want 0", rdy);
        end
    endtask

    task automatic test_false_start();
        align();
        rx = 1'b0;
        repeat (81) @(negedge clk_50m);
        rx = 1'b1;
        repeat (30 * 27) @(negedge clk_50m);
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL false_start_rdy got %b want 0", rdy);
        end
        send_frame(8'h5A, 1'b1, -1, 1'b0, 1'b0, -1);
        checks++;
        if ({data, rdy, ferr} !== {m_data, m_rdy, m_ferr}) begin
            errors++;
            $display("FAIL false_start_next got %h want %h", {data, rdy, ferr},
                     {m_data, m_rdy, m_ferr});
        end
        pulse_clr();
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0, -1, 1'b0, 1'b0, -1);
        checks++;
        if ({data, rdy, ferr} !== {8'h3C, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ferr_deliver got %h want 3C,1,1", {data, rdy, ferr});
        end
        idle_bits(2);
        checks++;
        if ({data, rdy, ferr, overrun} !== {m_data, m_rdy, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL ferr_settle got %h want %h", {data, rdy, ferr, overrun},
                     {m_data, m_rdy, m_ferr, m_ovr});
        end
        pulse_clr();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, -1, 1'b0, 1'b0, -1);
        send_frame(8'h22, 1'b1, -1, 1'b1, 1'b0, -1);
        checks++;
        if ({data, rdy, overrun} !== {8'h22, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL overrun_set got %h want 22,1,1", {data, rdy, overrun});
        end
        pulse_clr();
        checks++;
        if ({rdy, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_clr got %b want 00", {rdy, overrun});
        end
        send_frame(8'h11, 1'b1, -1, 1'b0, 1'b0, -1);
        send_frame(8'h22, 1'b1, -1, 1'b1, 1'b1, -1);
        checks++;
        if ({data, rdy, overrun} !== {m_data, m_rdy, m_ovr}) begin
            errors++;
            $display("FAIL coincident_clr got %h want %h", {data, rdy, overrun},
                     {m_data, m_rdy, m_ovr});
        end
        pulse_clr();
    endtask

    task automatic test_glitch();
        send_frame(8'h00, 1'b1, 4, 1'b0, 1'b0, -1);
        checks++;
`ifdef UART_RX_MAJORITY_EN
        if (data !== 8'h00 || data !== m_data) begin
            errors++;
            $display("FAIL glitch_data got %h want 00", data);
        end
`else
        if (data !== 8'h08 || data !== m_data) begin
            errors++;
            $display("FAIL glitch_data got %h want 08", data);
        end
`endif
    endtask

    task automatic test_reset_mid();
        send_frame(8'hFF, 1'b1, -1, 1'b0, 1'b0, 5);
        checks++;
        if ({data, rdy, ferr, overrun} !== 11'h000) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h want 000", {data, rdy, ferr, overrun});
        end
        m_data = 8'h00;
        model_clear();
        m_ferr = 1'b0;
        rst_n  = 1'b1;
        idle_bits(1);
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nodeliver got %b want 0", rdy);
        end
        send_frame(8'h81, 1'b1, -1, 1'b0, 1'b0, -1);
        checks++;
        if ({data, rdy, ferr, overrun} !== {m_data, m_rdy, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL reset_mid_next got %h want %h", {data, rdy, ferr, overrun},
                     {m_data, m_rdy, m_ferr, m_ovr});
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        bit         cont;
        bit         clr;
        bit         prev_ok;
        prev_ok = 1'b0;
        for (int n = 0; n < 4; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            cont = prev_ok && $urandom_range(0, 1) == 1;
            clr  = $urandom_range(0, 1) == 1;
            if (!cont && $urandom_range(0, 1) == 1) pulse_clr();
            send_frame(b, stop, -1, cont, clr, -1);
            checks++;
            if (data !== m_data) begin
                errors++;
                $display("FAIL rand_data[%0d] got %h want %h", n, data, m_data);
            end
            checks++;
            if ({rdy, ferr, overrun} !== {m_rdy, m_ferr, m_ovr}) begin
                errors++;
                $display("FAIL rand_flags[%0d] got %b want %b", n,
                         {rdy, ferr, overrun}, {m_rdy, m_ferr, m_ovr});
            end
            if (!stop) idle_bits(2);
            prev_ok = stop;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
